// File: rtl/fp16_subnormal_unpack.sv
// FP16 input unpacker: splits a half-precision word into sign / biased exponent / mantissa
// with hidden bit at [10], normalizing subnormals one left shift per cycle.
`timescale 1ns/1ps
module fp16_subnormal_unpack #(
    parameter int unsigned BIAS  = 15,
    parameter int unsigned EXP_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [EXP_W-1:0] exp_final,
    output logic [10:0]      norm_sum,
    output logic             is_zero,
    output logic             is_sub,
    output logic             is_inf,
    output logic             is_nan
);

    // All-ones exponent field (inf/nan) follows from the bias: 2*BIAS+1.
    localparam logic [4:0] EXP_MAX = 5'(2 * BIAS + 1);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    state_t           state_q;
    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic [10:0]      mant_q;
    logic [3:0]       flags_q;   // {nan, inf, sub, zero}

    state_t           state_d;
    logic             sign_d;
    logic [EXP_W-1:0] exp_d;
    logic [10:0]      mant_d;
    logic [3:0]       flags_d;

    logic [4:0]       in_exp;
    logic [9:0]       in_frac;

    assign in_exp  = in_data[14:10];
    assign in_frac = in_data[9:0];

    // Classification of the word on in_data, applied on whichever edge accepts it.
    always_comb begin
        state_d = DONE;
        sign_d  = in_data[15];
        exp_d   = '0;
        mant_d  = '0;
        flags_d = '0;
        if (in_exp == 5'd0) begin
            if (in_frac == 10'd0) begin
                flags_d = 4'b0001;
            end else begin
                state_d = NORM;
                exp_d   = EXP_W'(1);
                mant_d  = {1'b0, in_frac};
                flags_d = 4'b0010;
            end
        end else if (in_exp == EXP_MAX) begin
            exp_d = EXP_W'(EXP_MAX);
            if (in_frac == 10'd0) begin
                flags_d = 4'b0100;
            end else begin
                mant_d  = {1'b0, in_frac};
                flags_d = 4'b1000;
            end
        end else begin
            exp_d  = EXP_W'(in_exp);
            mant_d = {1'b1, in_frac};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= state_d;
                        sign_q  <= sign_d;
                        exp_q   <= exp_d;
                        mant_q  <= mant_d;
                        flags_q <= flags_d;
                    end
                end
                NORM: begin
                    mant_q <= mant_q << 1;
                    exp_q  <= exp_q - EXP_W'(1);
                    // Bit 9 now becomes the hidden bit after this shift.
                    if (mant_q[9]) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            state_q <= state_d;
                            sign_q  <= sign_d;
                            exp_q   <= exp_d;
                            mant_q  <= mant_d;
                            flags_q <= flags_d;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign sign      = sign_q;
    assign exp_final = exp_q;
    assign norm_sum  = mant_q;
    assign is_zero   = flags_q[0];
    assign is_sub    = flags_q[1];
    assign is_inf    = flags_q[2];
    assign is_nan    = flags_q[3];

endmodule

// File: tb/tb_fp16_subnormal_unpack.sv
// Self-checking bench for fp16_subnormal_unpack: arithmetic reference model with a per-cycle
// compare process, plus literal expectations for the hand-computed vectors.
`timescale 1ns/1ps
module tb_fp16_subnormal_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        sign;
    logic [6:0]  exp_final;
    logic [10:0] norm_sum;
    logic        is_zero, is_sub, is_inf, is_nan;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    fp16_subnormal_unpack #(.BIAS(15), .EXP_W(7)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign(sign), .exp_final(exp_final), .norm_sum(norm_sum),
        .is_zero(is_zero), .is_sub(is_sub), .is_inf(is_inf), .is_nan(is_nan)
    );

    typedef struct {
        logic        sign;
        logic [6:0]  exp;
        logic [10:0] mant;
        logic [3:0]  flags;   // {nan, inf, sub, zero}
        int          lat;
        int          acc;
    } exp_t;

    // Reference: value-level decode of FP16; subnormals shift until the leading one reaches bit 10.
    function automatic exp_t model(input logic [15:0] w);
        exp_t r;
        int e, f, p, s;
        e = int'(w[14:10]);
        f = int'(w[9:0]);
        r.sign = w[15]; r.exp = '0; r.mant = '0; r.flags = '0; r.lat = 1; r.acc = 0;
        if (e == 0 && f == 0) begin
            r.flags = 4'b0001;
        end else if (e == 0) begin
            p = 0;
            for (int i = 0; i < 10; i++) if (((f >> i) & 1) != 0) p = i;
            s = 10 - p;
            r.mant  = 11'(f * (1 << s));
            r.exp   = 7'(1 - s);
            r.flags = 4'b0010;
            r.lat   = 1 + s;
        end else if (e == 31) begin
            r.exp   = 7'd31;
            r.mant  = 11'(f);
            r.flags = (f == 0) ? 4'b0100 : 4'b1000;
        end else begin
            r.exp  = 7'(e);
            r.mant = 11'(1024 + f);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    exp_t q[$];
    exp_t h;
    bit   seen = 1'b0;
    int   wait_n = 0;

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            seen   = 1'b0;
            wait_n = 0;
        end else begin
            if (q.size() == 0) begin
                chk("idle_out_valid", 32'(out_valid), 32'd0);
                chk("idle_in_ready", 32'(in_ready), 32'd1);
            end else if (!out_valid) begin
                chk("busy_in_ready", 32'(in_ready), 32'd0);
                wait_n++;
                if (wait_n > 20) begin
                    chk("out_timeout", 32'd0, 32'd1);
                    void'(q.pop_front());
                    wait_n = 0;
                end
            end else begin
                h = q[0];
                chk("sign", 32'(sign), 32'(h.sign));
                chk("exp_final", 32'(exp_final), 32'(h.exp));
                chk("norm_sum", 32'(norm_sum), 32'(h.mant));
                chk("flags", 32'({is_nan, is_inf, is_sub, is_zero}), 32'(h.flags));
                chk("done_in_ready", 32'(in_ready), 32'(out_ready));
                if (!seen) begin
                    chk("latency", 32'(cycle - h.acc), 32'(h.lat));
                    seen = 1'b1;
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    seen   = 1'b0;
                    wait_n = 0;
                end
            end
            if (in_valid && in_ready) begin
                h = model(in_data);
                h.acc = cycle;
                q.push_back(h);
            end
        end
    end

    // Present a word and hold it until accepted; in_valid stays high on return.
    task automatic put(input logic [15:0] w);
        int n;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 40) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [15:0] w);
        @(posedge clk); #1;
        put(w);
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    task automatic wait_out(output int busy);
        int n;
        busy = 0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid) break;
            if (!in_ready) busy++;
            n++;
            if (n > 40) begin
                chk("wait_out_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic lit(input string name, input logic s, input logic [6:0] e,
                       input logic [10:0] m, input logic [3:0] fl);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_sign"}, 32'(sign), 32'(s));
        chk({name, "_exp"}, 32'(exp_final), 32'(e));
        chk({name, "_mant"}, 32'(norm_sum), 32'(m));
        chk({name, "_flags"}, 32'({is_nan, is_inf, is_sub, is_zero}), 32'(fl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [15:0] norm_words[5] = '{16'h3555, 16'hC000, 16'h7BFF, 16'h0400, 16'h8000};
    logic [15:0] mix_words[6]  = '{16'h03FF, 16'h3555, 16'h0155, 16'hFBFF, 16'h0001, 16'h7E01};

    initial begin
        int busy;
        int c0;
        int n;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sign", 32'(sign), 32'd0);
        chk("rst_exp", 32'(exp_final), 32'd0);
        chk("rst_mant", 32'(norm_sum), 32'd0);
        chk("rst_flags", 32'({is_nan, is_inf, is_sub, is_zero}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);

        send(16'h3C00); wait_out(busy);
        lit("one", 1'b0, 7'd15, 11'h400, 4'b0000);
        chk("one_busy", 32'(busy), 32'd0);

        send(16'h8001); wait_out(busy);
        lit("sub_min", 1'b1, 7'h77, 11'h400, 4'b0010);
        chk("sub_min_busy", 32'(busy), 32'd10);

        send(16'h0200); wait_out(busy);
        lit("sub_max", 1'b0, 7'd0, 11'h400, 4'b0010);
        chk("sub_max_busy", 32'(busy), 32'd1);

        send(16'h0000); wait_out(busy);
        lit("zero", 1'b0, 7'd0, 11'h000, 4'b0001);
        send(16'h7C00); wait_out(busy);
        lit("inf", 1'b0, 7'd31, 11'h000, 4'b0100);
        send(16'hFE00); wait_out(busy);
        lit("nan", 1'b1, 7'd31, 11'h200, 4'b1000);

        // Backpressure: first result held while the next word waits.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h3C00);
        in_data  = 16'h4000;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            lit("held", 1'b0, 7'd15, 11'h400, 4'b0000);
            chk("held_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        put(16'h4000);
        in_valid = 1'b0;
        wait_out(busy);
        lit("two", 1'b0, 7'd16, 11'h400, 4'b0000);
        chk("two_busy", 32'(busy), 32'd0);

        // Back-to-back normals: one word per cycle.
        @(posedge clk); #1;
        c0 = cycle;
        foreach (norm_words[i]) put(norm_words[i]);
        in_valid = 1'b0;
        chk("throughput_cycles", 32'(cycle - c0), 32'd5);

        @(posedge clk); #1;
        foreach (mix_words[i]) put(mix_words[i]);
        in_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("mix_drained", 32'(q.size()), 32'd0);

        // Reset in the middle of normalization drops the pending word.
        send(16'h0001);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_exp", 32'(exp_final), 32'd0);
        chk("midrst_mant", 32'(norm_sum), 32'd0);
        chk("midrst_is_sub", 32'(is_sub), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        send(16'h3C00); wait_out(busy);
        lit("after_rst", 1'b0, 7'd15, 11'h400, 4'b0000);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
